// File: rtl/preprocess_pkt_sequencer_pkg.sv
// ============================================================================
// Module  : preprocess_pkt_sequencer_pkg
// Brief   : Shared framing/output-FSM encodings and FIFO margin constant.
// Revision: 1.0
// ============================================================================
`default_nettype none

package preprocess_pkt_sequencer_pkg;

    typedef enum logic [0:0] {
        FRAME_HDR  = 1'b0,
        FRAME_BODY = 1'b1
    } frame_state_t;

    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    // in_rdy drops this many words before the FIFO is truly full
    localparam int c_FIFO_MARGIN = 4;

endpackage

`default_nettype wire

// File: rtl/pkt_word_fifo.sv
// ============================================================================
// Module  : pkt_word_fifo
// Brief   : First-word fall-through synchronous FIFO with occupancy output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pkt_word_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   occupancy
);

    localparam int                  c_DEPTH       = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] c_DEPTH_LEVEL = (DEPTH_BITS + 1)'(c_DEPTH);

    logic [WIDTH-1:0]    r_mem [c_DEPTH];
    logic [DEPTH_BITS:0] r_wr_ptr;
    logic [DEPTH_BITS:0] r_rd_ptr;
    logic                w_do_wr;
    logic                w_do_rd;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign occupancy = r_wr_ptr - r_rd_ptr;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == c_DEPTH_LEVEL);
    assign w_do_wr   = wr_en && !full;
    assign w_do_rd   = rd_en && !empty;
    assign rd_data   = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/preprocess_pkt_sequencer.sv
// ============================================================================
// Module  : preprocess_pkt_sequencer
// Brief   : Buffers packets until every preprocess source has a result, then
//           releases them downstream one packet at a time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module preprocess_pkt_sequencer
    import preprocess_pkt_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_RESULTS     = 3,
    parameter int FIFO_DEPTH_BITS = 9,
    parameter int PKT_CNT_BITS    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic                   in_wr,
    output logic                   in_rdy,
    input  logic [NUM_RESULTS-1:0] result_vld,
    output logic                   rd_results,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic                   out_wr,
    input  logic                   out_rdy,
    output logic                   overflow_err
);

    localparam int c_FIFO_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [FIFO_DEPTH_BITS:0] c_NEAR_FULL_LEVEL =
        (FIFO_DEPTH_BITS + 1)'(2 ** FIFO_DEPTH_BITS - c_FIFO_MARGIN);

    logic [c_FIFO_WIDTH-1:0]     w_head;
    logic [FIFO_DEPTH_BITS:0]    w_occ;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;

    frame_state_t                r_in_frame;
    frame_state_t                w_in_frame_next;
    frame_state_t                r_out_frame;
    frame_state_t                w_out_frame_next;
    out_state_t                  r_out_state;
    out_state_t                  w_out_state_next;

    logic                        w_in_is_ctrl;
    logic                        w_in_accept;
    logic                        w_in_drop;
    logic                        w_in_eop;
    logic                        w_head_is_ctrl;
    logic                        w_out_pop;
    logic                        w_out_eop;
    logic                        w_release;
    logic                        w_rd_results;
    logic [NUM_RESULTS-1:0]      w_pend_nz;
    logic [NUM_RESULTS-1:0]      w_res_drop;

    logic [PKT_CNT_BITS-1:0]     r_pkt_cnt;
    logic                        r_in_rdy;
    logic                        r_overflow;

    pkt_word_fifo #(
        .WIDTH      (c_FIFO_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (in_wr),
        .wr_data   ({in_data, in_ctrl}),
        .rd_en     (w_out_pop),
        .rd_data   (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .occupancy (w_occ)
    );

    assign w_in_is_ctrl   = (in_ctrl != '0);
    assign w_in_accept    = in_wr && !w_fifo_full;
    assign w_in_drop      = in_wr && w_fifo_full;
    assign w_in_eop       = w_in_accept && w_in_is_ctrl && (r_in_frame == FRAME_BODY);

    assign w_head_is_ctrl = (w_head[CTRL_WIDTH-1:0] != '0);
    assign w_out_pop      = (r_out_state == OUT_SEND) && out_rdy && !w_fifo_empty;
    assign w_out_eop      = w_out_pop && w_head_is_ctrl && (r_out_frame == FRAME_BODY);
    assign w_release      = (r_pkt_cnt != '0) && (&w_pend_nz);

    // Input framing parser
    always_comb begin
        w_in_frame_next = r_in_frame;
        if (w_in_accept) begin
            case (r_in_frame)
                FRAME_HDR:  if (!w_in_is_ctrl) w_in_frame_next = FRAME_BODY;
                FRAME_BODY: if (w_in_is_ctrl)  w_in_frame_next = FRAME_HDR;
                default:    w_in_frame_next = FRAME_HDR;
            endcase
        end
    end

    // Output framing tracker mirrors the input parser on popped words
    always_comb begin
        w_out_frame_next = r_out_frame;
        if (w_out_pop) begin
            case (r_out_frame)
                FRAME_HDR:  if (!w_head_is_ctrl) w_out_frame_next = FRAME_BODY;
                FRAME_BODY: if (w_head_is_ctrl)  w_out_frame_next = FRAME_HDR;
                default:    w_out_frame_next = FRAME_HDR;
            endcase
        end
    end

    always_comb begin
        w_out_state_next = r_out_state;
        w_rd_results     = 1'b0;
        case (r_out_state)
            OUT_IDLE: begin
                if (w_release) begin
                    w_out_state_next = OUT_SEND;
                    w_rd_results     = 1'b1;
                end
            end
            OUT_SEND: begin
                if (w_out_eop) begin
                    w_out_state_next = OUT_IDLE;
                end
            end
            default: w_out_state_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_frame  <= FRAME_HDR;
            r_out_frame <= FRAME_HDR;
            r_out_state <= OUT_IDLE;
        end else begin
            r_in_frame  <= w_in_frame_next;
            r_out_frame <= w_out_frame_next;
            r_out_state <= w_out_state_next;
        end
    end

    // Complete packets in the FIFO; saturates rather than wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_cnt <= '0;
        end else if (w_in_eop && !w_out_eop) begin
            if (!(&r_pkt_cnt)) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end else if (w_out_eop && !w_in_eop) begin
            if (r_pkt_cnt != '0) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RESULTS; gi++) begin : g_pend
        logic [PKT_CNT_BITS-1:0] r_pend;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pend <= '0;
            end else if (result_vld[gi] && !w_rd_results) begin
                if (!(&r_pend)) begin
                    r_pend <= r_pend + 1'b1;
                end
            end else if (!result_vld[gi] && w_rd_results) begin
                r_pend <= r_pend - 1'b1;
            end
        end

        assign w_pend_nz[gi]  = (r_pend != '0);
        assign w_res_drop[gi] = result_vld[gi] && (&r_pend) && !w_rd_results;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_rdy   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_in_rdy   <= (w_occ < c_NEAR_FULL_LEVEL);
            r_overflow <= w_in_drop || (|w_res_drop);
        end
    end

    assign in_rdy       = r_in_rdy;
    assign overflow_err = r_overflow;
    assign rd_results   = w_rd_results;
    assign out_wr       = w_out_pop;

    // Head is only driven out while sending so idle outputs stay at zero
    always_comb begin
        out_data = '0;
        out_ctrl = '0;
        if ((r_out_state == OUT_SEND) && !w_fifo_empty) begin
            out_data = w_head[c_FIFO_WIDTH-1:CTRL_WIDTH];
            out_ctrl = w_head[CTRL_WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire
